stall_ctrl: RTL and testbench
=============================

# stall_ctrl

Pipeline stall/flush controller for the 5-stage MIPS core. It consumes the hazard unit's combinational `hazard` request, the ID-stage branch/jump taken flush request and the HALT decode. It drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble insert. It also sequences pipeline drain on HALT, gates everything on the debug-unit `i_valid` step enable, and keeps stall statistics for the debug unit.

## Interface
- `NB_CNT`, 32, width of stall statistics counters
- `MAX_STALL`, 4, consecutive stall cycles allowed before watchdog error
- `DRAIN_CYCLES`, 3, cycles to drain EX/MEM/WB after HALT enters ID
- `i_clock` in 1: core clock, rising-edge
- `i_reset` in 1: asynchronous, active-low reset
- `i_valid` in 1: debug step/run enable; 0 freezes the pipeline and this block
- `i_hazard` in 1: stall request from the hazard unit, combinational, same cycle
- `i_flush_req` in 1: branch/jump taken, resolved in ID
- `i_halt` in 1: HALT instruction decoded in ID
- `o_pc_we` out 1: PC write enable
- `o_ifid_we` out 1: IF/ID register write enable
- `o_ifid_flush` out 1: load NOP into IF/ID
- `o_idex_bubble` out 1: load NOP (all control zero) into ID/EX
- `o_halted` out 1: pipeline drained after HALT
- `o_stall_err` out 1: sticky watchdog error
- `o_stall_cnt` out `NB_CNT`: total stall cycles, saturating
- `o_flush_cnt` out `NB_CNT`: total flush cycles, saturating

## Operation
- FSM states: RUN, STALL, DRAIN, HALTED. The enables are Mealy outputs from the current state and the inputs. Counters and state registers update on the rising edge, and only when `i_valid`=1.
- `i_valid`=0: `o_pc_we`, `o_ifid_we`, `o_ifid_flush` and `o_idex_bubble` are all 0. State, counters and the watchdog hold.
- Event priority in RUN/STALL: `i_hazard` > `i_halt` > `i_flush_req`.
  - A branch in ID that has a hazard is unresolved, so the flush is ignored that cycle; ID re-asserts it after the stall.
  - A HALT in ID that has a hazard waits for the hazard to clear.
- RUN, no event: `o_pc_we`=1, `o_ifid_we`=1, others 0.
- RUN/STALL with `i_hazard`: `o_pc_we`=0, `o_ifid_we`=0, `o_idex_bubble`=1. Next state is STALL. The consecutive-stall counter `run_len` increments, saturating at `MAX_STALL`+1.
- STALL with `i_hazard`=0: behaves as RUN for that cycle's outputs. Next state is RUN and `run_len` clears.
- `i_flush_req` (accepted): `o_pc_we`=1, `o_ifid_we`=1, `o_ifid_flush`=1. `o_flush_cnt` increments.
- `i_halt` (accepted):
  - Outputs: `o_pc_we`=0, `o_ifid_we`=0, `o_idex_bubble`=1.
  - Next state is DRAIN, and the drain counter loads `DRAIN_CYCLES`-1.
- DRAIN:
  - Outputs: `o_pc_we`=0, `o_ifid_we`=0, `o_idex_bubble`=1.
  - The drain counter decrements each valid cycle; at 0 the next state is HALTED.
  - All inputs are ignored.
- HALTED: `o_halted`=1, all enables 0, `o_idex_bubble`=0. The only exit is reset.
- `o_stall_cnt` increments on every valid cycle with `o_pc_we`=0 in RUN/STALL. DRAIN and HALTED cycles are not counted.
- Both statistics counters saturate at all-ones and never wrap.
- `o_stall_err` sets when `run_len` would exceed `MAX_STALL`. It stays set until reset and does not alter the stall behaviour.

## Timing
- Reset (`i_reset`=0, asynchronous):
  - State is RUN; counters, `run_len` and `o_stall_err` are 0; `o_halted`=0.
  - While reset is held, all enables and `o_ifid_flush`/`o_idex_bubble` are forced to 0.
- After deassertion: the first valid cycle with no event gives `o_pc_we`=1.
- Enable outputs have zero latency from `i_hazard`, `i_flush_req` and `i_halt`. Registered outputs (`o_halted`, counters, `o_stall_err`) reflect the previous edge.
- HALT accepted at edge N gives `o_halted`=1 after N+`DRAIN_CYCLES` valid edges. Invalid cycles extend this.
- Reset mid-DRAIN or mid-STALL returns immediately to RUN with all counters cleared.

## Configuration
- `STALL_STATS_EN` defined: `o_stall_cnt`, `o_flush_cnt`, `run_len` and the `o_stall_err` watchdog are implemented as specified.
- `STALL_STATS_EN` undefined: these logic blocks are removed. The ports remain and are tied to 0. FSM and enable behaviour are unchanged.

## Structure
- Shared package `pipe_ctrl_pkg`: FSM state encoding constants (RUN, STALL, DRAIN, HALTED) and the default `NB_CNT`.
- One sub-module, `sat_counter`: parameterised width, with enable, synchronous clear, asynchronous active-low reset and saturation at all-ones. It is instantiated for `o_stall_cnt` and `o_flush_cnt`.

## Test plan
- **Hazard for 1 cycle in RUN, `i_valid`=1:** that cycle gives `o_pc_we`=0, `o_ifid_we`=0, `o_idex_bubble`=1. The next cycle gives `o_pc_we`=1, and `o_stall_cnt`=1.
- **`i_hazard` and `i_flush_req` both high, then flush only:**
  - First cycle: stall outputs, `o_ifid_flush`=0.
  - Second cycle: `o_ifid_flush`=1 and `o_flush_cnt`=1.
- **`i_hazard` held 5 cycles, `MAX_STALL`=4:** `o_stall_err` rises after the 5th stall edge and stays 1 after the hazard clears. `o_stall_cnt`=5.
- **`i_halt` pulse, `DRAIN_CYCLES`=3:** `o_halted`=1 exactly 3 valid edges later.
  - `o_idex_bubble`=1 for the halt cycle and the 2 following DRAIN cycles.
  - In HALTED, later `i_flush_req` and `i_hazard` have no effect.
- **`i_valid`=0 for 4 cycles mid-DRAIN:**
  - All enables are 0 and the drain count holds; `o_halted` is delayed by 4 cycles.
  - Asserting `i_reset`=0 then clears `o_halted` asynchronously and restores RUN.
- **Build without `STALL_STATS_EN`, repeat the hazard scenario:** identical enable waveforms; `o_stall_cnt`, `o_flush_cnt` and `o_stall_err` are 0 throughout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control blocks: FSM state encoding
// and the default statistics counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } pipe_state_t;

  localparam int NB_CNT_DEF = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count up on enable; hold once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Drives the PC / IF-ID write enables, IF-ID flush and ID-EX bubble from the
// hazard, branch-flush and HALT requests, drains the back end on HALT and
// freezes completely while i_valid is low.
// Build option: define STALL_STATS_EN to implement the stall/flush statistics
// counters and the consecutive-stall watchdog; otherwise those ports read 0.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_RUN    | normal flow, requests resolved in priority hazard>halt>flush
// ST_STALL  | previous cycle stalled on a hazard
// ST_DRAIN  | HALT in ID, bubbling while EX/MEM/WB empty out
// ST_HALTED | pipeline drained, frozen until reset
module stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_CNT       = NB_CNT_DEF,
  parameter int MAX_STALL    = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_hazard,
  input  logic              i_flush_req,
  input  logic              i_halt,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_halted,
  output logic              o_stall_err,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  pipe_state_t   state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble;
  logic          stall_evt, halt_evt, flush_evt;

  // State and drain counter; the next-state logic already holds them when
  // i_valid is low.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Mealy enables and next state. A branch or HALT seen together with a
  // hazard is not accepted; ID presents it again once the hazard clears.
  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_evt   = 1'b0;
    halt_evt    = 1'b0;
    flush_evt   = 1'b0;
    if (i_valid) begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (i_hazard) begin
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
            state_nxt   = ST_STALL;
          end else if (i_halt) begin
            idex_bubble = 1'b1;
            halt_evt    = 1'b1;
            state_nxt   = ST_DRAIN;
            drain_nxt   = DW'(DRAIN_CYCLES - 1);
          end else if (i_flush_req) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
            state_nxt  = ST_RUN;
          end else begin
            pc_we     = 1'b1;
            ifid_we   = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        ST_DRAIN: begin
          idex_bubble = 1'b1;
          // The halt cycle itself is the first of the drain cycles, so the
          // last DRAIN cycle is the one that decrements the count to zero.
          if (drain_cnt <= DW'(1)) begin
            drain_nxt = '0;
            state_nxt = ST_HALTED;
          end else begin
            drain_nxt = drain_cnt - DW'(1);
          end
        end
        ST_HALTED: begin
          state_nxt = ST_HALTED;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // While reset is held the state decodes as RUN, so the enables are masked
  // to keep the pipeline frozen until reset is released.
  assign o_pc_we       = pc_we & i_reset;
  assign o_ifid_we     = ifid_we & i_reset;
  assign o_ifid_flush  = ifid_flush & i_reset;
  assign o_idex_bubble = idex_bubble & i_reset;
  assign o_halted      = (state == ST_HALTED);

`ifdef STALL_STATS_EN
  localparam int RL_W = $clog2(MAX_STALL + 2);

  logic [RL_W-1:0] run_len;
  logic            stall_err;

  // Consecutive-stall length, saturating one past the watchdog limit.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      run_len <= '0;
    end else if (stall_evt) begin
      if (run_len < RL_W'(MAX_STALL + 1)) begin
        run_len <= run_len + RL_W'(1);
      end
    end else if (i_valid) begin
      run_len <= '0;
    end
  end

  // Sticky watchdog: flags a stall about to run past MAX_STALL cycles.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      stall_err <= 1'b0;
    end else if (stall_evt && (run_len >= RL_W'(MAX_STALL))) begin
      stall_err <= 1'b1;
    end
  end

  assign o_stall_err = stall_err;

  // Every RUN/STALL cycle with the PC held counts as a stall (hazard or HALT).
  sat_counter #(.W(NB_CNT)) u_stall_cnt (
    .clk   (i_clock),
    .rst_n (i_reset),
    .clr   (1'b0),
    .en    (stall_evt | halt_evt),
    .cnt   (o_stall_cnt)
  );

  sat_counter #(.W(NB_CNT)) u_flush_cnt (
    .clk   (i_clock),
    .rst_n (i_reset),
    .clr   (1'b0),
    .en    (flush_evt),
    .cnt   (o_flush_cnt)
  );
`else
  logic [34:0] unused_stats;
  assign unused_stats = {stall_evt, halt_evt, flush_evt, 32'(MAX_STALL)};

  assign o_stall_err = 1'b0;
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;

  logic        clk;
  logic        rst_b, valid, hazard, flush_req, halt;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, halted, stall_err;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct {
    int          id;
    logic [3:0]  en;
    logic        hlt;
    logic        err;
    logic [31:0] s;
    logic [31:0] f;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_push = 0;

  stall_ctrl #(.NB_CNT(32), .MAX_STALL(4), .DRAIN_CYCLES(3)) dut (
    .i_clock       (clk),
    .i_reset       (rst_b),
    .i_valid       (valid),
    .i_hazard      (hazard),
    .i_flush_req   (flush_req),
    .i_halt        (halt),
    .o_pc_we       (pc_we),
    .o_ifid_we     (ifid_we),
    .o_ifid_flush  (ifid_flush),
    .o_idex_bubble (idex_bubble),
    .o_halted      (halted),
    .o_stall_err   (stall_err),
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sc(input int v);
`ifdef STALL_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic se(input logic v);
`ifdef STALL_STATS_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  // en = {pc_we, ifid_we, ifid_flush, idex_bubble} expected during this cycle
  task automatic step(input logic rb, input logic v, input logic hz, input logic fl,
                      input logic ht, input logic [3:0] en, input logic hl,
                      input logic er, input int s, input int f);
    exp_t e;
    @(posedge clk);
    #1;
    rst_b = rb; valid = v; hazard = hz; flush_req = fl; halt = ht;
    n_push++;
    e.id = n_push; e.en = en; e.hlt = hl; e.err = se(er); e.s = sc(s); e.f = sc(f);
    q.push_back(e);
  endtask

  // Monitor: the DUT presents its outputs every cycle; check each at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== e.en || halted !== e.hlt ||
            stall_err !== e.err || stall_cnt !== e.s || flush_cnt !== e.f) begin
          n_bad++;
          $display("FAIL vec%0d: got en=%b halted=%b err=%b scnt=%0d fcnt=%0d, want en=%b halted=%b err=%b scnt=%0d fcnt=%0d",
                   e.id, {pc_we, ifid_we, ifid_flush, idex_bubble}, halted, stall_err,
                   stall_cnt, flush_cnt, e.en, e.hlt, e.err, e.s, e.f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0; valid = 1'b0; hazard = 1'b0; flush_req = 1'b0; halt = 1'b0;
    //    rb v  hz fl ht  en       hl er  s  f
    step(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // 1 reset held
    step(1, 1, 0, 0, 0, 4'b1100, 0, 0, 0, 0);  // 2 first run cycle
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 0, 0);  // 3 single hazard
    step(1, 1, 0, 0, 0, 4'b1100, 0, 0, 1, 0);  // 4
    step(1, 1, 1, 1, 0, 4'b0001, 0, 0, 1, 0);  // 5 hazard masks flush
    step(1, 1, 0, 1, 0, 4'b1110, 0, 0, 2, 0);  // 6 flush from STALL
    step(1, 1, 0, 0, 0, 4'b1100, 0, 0, 2, 1);  // 7
    step(1, 0, 1, 0, 0, 4'b0000, 0, 0, 2, 1);  // 8 invalid freezes
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 2, 1);  // 9..13 five hazard cycles
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 3, 1);
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 4, 1);
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 5, 1);
    step(1, 1, 1, 0, 0, 4'b0001, 0, 0, 6, 1);
    step(1, 1, 0, 0, 0, 4'b1100, 0, 1, 7, 1);  // 14 watchdog set
    step(1, 1, 0, 0, 0, 4'b1100, 0, 1, 7, 1);  // 15 watchdog sticky
    step(1, 1, 1, 0, 1, 4'b0001, 0, 1, 7, 1);  // 16 halt waits on hazard
    step(1, 1, 0, 0, 1, 4'b0001, 0, 1, 8, 1);  // 17 halt accepted
    step(1, 1, 1, 1, 0, 4'b0001, 0, 1, 9, 1);  // 18 DRAIN ignores inputs
    step(1, 0, 0, 0, 0, 4'b0000, 0, 1, 9, 1);  // 19..22 invalid mid-DRAIN
    step(1, 0, 0, 1, 0, 4'b0000, 0, 1, 9, 1);
    step(1, 0, 1, 0, 0, 4'b0000, 0, 1, 9, 1);
    step(1, 0, 0, 0, 0, 4'b0000, 0, 1, 9, 1);
    step(1, 1, 0, 0, 0, 4'b0001, 0, 1, 9, 1);  // 23 last DRAIN cycle
    step(1, 1, 1, 0, 0, 4'b0000, 1, 1, 9, 1);  // 24 HALTED
    step(1, 1, 0, 1, 0, 4'b0000, 1, 1, 9, 1);  // 25 flush ignored
    step(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // 26 async reset
    step(1, 1, 0, 0, 0, 4'b1100, 0, 0, 0, 0);  // 27
    step(1, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 0);  // 28 halt
    step(1, 1, 0, 0, 0, 4'b0001, 0, 0, 1, 0);  // 29 DRAIN
    step(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);  // 30 reset mid-DRAIN
    step(1, 1, 0, 0, 0, 4'b1100, 0, 0, 0, 0);  // 31 back in RUN
    step(1, 1, 0, 0, 1, 4'b0001, 0, 0, 0, 0);  // 32 halt, no gaps
    step(1, 1, 0, 0, 0, 4'b0001, 0, 0, 1, 0);  // 33
    step(1, 1, 0, 0, 0, 4'b0001, 0, 0, 1, 0);  // 34
    step(1, 1, 0, 0, 0, 4'b0000, 1, 0, 1, 0);  // 35 halted after 3 edges
    @(negedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
